// File: rtl/onehot_seq_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : onehot_dec_pkg
// Brief  : Shared state encoding, mode constants and one-hot helper for the
//          one-hot sequencing decoder.
// Rev    : 1.0  initial release
// ============================================================================
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned ONEHOT_MAX_W = 256;

    // Callers truncate the result to their own width; an index at or beyond
    // 'width' yields all-zero so out-of-range selects decode to no line.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(
        input int unsigned idx,
        input int unsigned width
    );
        logic [ONEHOT_MAX_W-1:0] v;
        v = '0;
        if ((idx < width) && (idx < ONEHOT_MAX_W)) begin
            v[idx[7:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_seq_decoder_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module : onehot_dwell_timer
// Brief  : Loadable down-counter with a latched reload value; o_terminal is
//          high while the count sits at zero.
// Rev    : 1.0  initial release
// ============================================================================
module onehot_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    input  logic               i_run,
    output logic               o_terminal
);

    logic [DWELL_W-1:0] r_count;
    logic [DWELL_W-1:0] r_reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_reload <= '0;
        end else if (i_load) begin
            r_count  <= i_load_val;
            r_reload <= i_load_val;
        end else if (i_run) begin
            r_count <= (r_count == '0) ? r_reload : r_count - 1'b1;
        end
    end

    assign o_terminal = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/onehot_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module : onehot_seq_decoder
// Brief  : Registered binary-to-one-hot decoder with enable, range checking
//          and a timed scan mode (scan built only with ONEHOT_SCAN_EN).
// Rev    : 1.0  initial release
// ============================================================================
module onehot_seq_decoder
    import onehot_dec_pkg::*;
#(
    parameter int  OUT_N   = 8,
    parameter int  DWELL_W = 8,
    localparam int SEL_W   = $clog2(OUT_N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               load,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_N-1:0]   out,
    output logic               busy,
    output logic               wrap,
    output logic               range_err
);

    localparam logic [1:0] c_S_IDLE   = ST_IDLE;
    localparam logic [1:0] c_S_DIRECT = ST_DIRECT;

    logic [1:0]       r_state;
    logic [1:0]       w_nxt_state;
    logic [OUT_N-1:0] r_out;
    logic [OUT_N-1:0] w_nxt_out;
    logic             r_busy;
    logic             w_nxt_busy;
    logic             r_wrap;
    logic             w_nxt_wrap;
    logic             r_range_err;
    logic             w_nxt_range_err;
    logic             w_sel_bad;

    assign w_sel_bad = (32'(sel) >= 32'(OUT_N));

`ifdef ONEHOT_SCAN_EN
    localparam logic [1:0] c_S_SCAN = ST_SCAN;

    logic [SEL_W-1:0] r_index;
    logic [SEL_W-1:0] w_nxt_index;
    logic [SEL_W-1:0] w_index_inc;
    logic             w_tmr_load;
    logic             w_tmr_run;
    logic             w_tmr_terminal;

    assign w_index_inc = (32'(r_index) == 32'(OUT_N - 1)) ? '0 : r_index + 1'b1;

    onehot_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (dwell),
        .i_run      (w_tmr_run),
        .o_terminal (w_tmr_terminal)
    );
`else
    logic w_unused_scan;
    assign w_unused_scan = ^{mode, load, dwell, r_state};
`endif

    always_comb begin
        w_nxt_state     = c_S_IDLE;
        w_nxt_out       = '0;
        w_nxt_busy      = 1'b0;
        w_nxt_wrap      = 1'b0;
        w_nxt_range_err = 1'b0;
`ifdef ONEHOT_SCAN_EN
        w_nxt_index     = r_index;
        w_tmr_load      = 1'b0;
        w_tmr_run       = 1'b0;
`endif
        if (!en) begin
            w_nxt_state = c_S_IDLE;
        end
`ifdef ONEHOT_SCAN_EN
        else if (load && (mode == MODE_SCAN)) begin
            w_nxt_state     = c_S_SCAN;
            w_nxt_index     = w_sel_bad ? '0 : sel;
            w_tmr_load      = 1'b1;
            w_nxt_out       = OUT_N'(onehot(32'(w_nxt_index), OUT_N));
            w_nxt_busy      = 1'b1;
            w_nxt_range_err = w_sel_bad;
        end else if ((r_state == c_S_SCAN) && !load) begin
            // Any load here is a direct-mode load and falls through to DIRECT.
            w_nxt_state = c_S_SCAN;
            w_tmr_run   = 1'b1;
            if (w_tmr_terminal) begin
                w_nxt_index = w_index_inc;
                w_nxt_wrap  = (w_index_inc == '0);
            end
            w_nxt_out  = OUT_N'(onehot(32'(w_nxt_index), OUT_N));
            w_nxt_busy = 1'b1;
        end
`endif
        else begin
            w_nxt_state     = c_S_DIRECT;
            w_nxt_out       = OUT_N'(onehot(32'(sel), OUT_N));
            w_nxt_range_err = w_sel_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_out       <= '0;
            r_busy      <= 1'b0;
            r_wrap      <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_out       <= w_nxt_out;
            r_busy      <= w_nxt_busy;
            r_wrap      <= w_nxt_wrap;
            r_range_err <= w_nxt_range_err;
        end
    end

`ifdef ONEHOT_SCAN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= '0;
        end else begin
            r_index <= w_nxt_index;
        end
    end
`endif

    assign out       = r_out;
    assign busy      = r_busy;
    assign wrap      = r_wrap;
    assign range_err = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_onehot_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_onehot_seq_decoder
// Brief  : Self-checking bench: OUT_N=8 and OUT_N=6 decoders on shared inputs,
//          checked each cycle against a behavioural model plus literal checks.
// Rev    : 1.0  initial release
// ============================================================================
module tb_onehot_seq_decoder;

`ifdef ONEHOT_SCAN_EN
    localparam bit SCAN_BUILT = 1'b1;
`else
    localparam bit SCAN_BUILT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       load;
    logic [2:0] sel;
    logic [7:0] dwell;

    logic [7:0] out8;
    logic       busy8, wrap8, rerr8;
    logic [5:0] out6;
    logic       busy6, wrap6, rerr6;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    onehot_seq_decoder #(.OUT_N(8), .DWELL_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
        .dwell(dwell), .out(out8), .busy(busy8), .wrap(wrap8), .range_err(rerr8)
    );

    onehot_seq_decoder #(.OUT_N(6), .DWELL_W(8)) u_dut6 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
        .dwell(dwell), .out(out6), .busy(busy6), .wrap(wrap6), .range_err(rerr6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: 'left' counts the cycles the current line still has to show.
    typedef struct {
        bit         scanning;
        int         line;
        int         left;
        int         dlat;
        logic [7:0] out;
        bit         busy;
        bit         wrap;
        bit         rerr;
    } model_t;

    model_t m8, m6;

    function automatic model_t model_reset();
        model_t r;
        r.scanning = 0; r.line = 0; r.left = 0; r.dlat = 0;
        r.out = 8'h00; r.busy = 0; r.wrap = 0; r.rerr = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t m, int n, bit i_en, bit i_mode,
                                          bit i_load, int i_sel, int i_dwell);
        model_t r;
        r = m;
        r.wrap = 0;
        r.rerr = 0;
        if (!i_en) begin
            r.scanning = 0;
        end else if (SCAN_BUILT && i_load && i_mode) begin
            r.scanning = 1;
            r.rerr     = (i_sel >= n);
            r.line     = (i_sel >= n) ? 0 : i_sel;
            r.dlat     = i_dwell;
            r.left     = i_dwell + 1;
        end else if (r.scanning && !i_load) begin
            r.left = r.left - 1;
            if (r.left == 0) begin
                r.line = (r.line + 1) % n;
                r.left = r.dlat + 1;
                r.wrap = (r.line == 0);
            end
        end else begin
            r.scanning = 0;
            r.rerr     = (i_sel >= n);
        end
        if (!i_en)           r.out = 8'h00;
        else if (r.scanning) r.out = 8'(1 << r.line);
        else if (i_sel < n)  r.out = 8'(1 << i_sel);
        else                 r.out = 8'h00;
        r.busy = r.scanning;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8 <= model_reset();
            m6 <= model_reset();
        end else begin
            m8 <= model_step(m8, 8, en, mode, load, int'(sel), int'(dwell));
            m6 <= model_step(m6, 6, en, mode, load, int'(sel), int'(dwell));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m8_out",  32'(out8),  32'(m8.out));
            check("m8_busy", 32'(busy8), 32'(m8.busy));
            check("m8_wrap", 32'(wrap8), 32'(m8.wrap));
            check("m8_rerr", 32'(rerr8), 32'(m8.rerr));
            check("m6_out",  32'(out6),  32'(m6.out));
            check("m6_busy", 32'(busy6), 32'(m6.busy));
            check("m6_wrap", 32'(wrap6), 32'(m6.wrap));
            check("m6_rerr", 32'(rerr6), 32'(m6.rerr));
        end
    end

    logic [7:0] scan_out  [7];
    bit         scan_wrap [7];
    logic [7:0] mid_out   [3];
    logic [7:0] exp8;

    initial begin
`ifdef ONEHOT_SCAN_EN
        scan_out  = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01};
        scan_wrap = '{0, 0, 0, 0, 0, 0, 1};
        mid_out   = '{8'h04, 8'h08, 8'h10};
`else
        scan_out  = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        scan_wrap = '{0, 0, 0, 0, 0, 0, 0};
        mid_out   = '{8'h04, 8'h04, 8'h04};
`endif
        rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel = 3'd0; dwell = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_out",  32'(out8),  32'h0);
        check("rst_busy", 32'(busy8), 32'h0);
        check("rst_wrap", 32'(wrap8), 32'h0);
        check("rst_rerr", 32'(rerr8), 32'h0);
        #1 rst = 1'b0;
        chk_on = 1'b1;

        // Direct sweep over every select value.
        en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            @(negedge clk);
            exp8 = 8'h01;
            exp8 = exp8 << s;
            check("sweep_out",  32'(out8),  32'(exp8));
            check("sweep_busy", 32'(busy8), 32'h0);
            if (s == 5) begin
                check("n6_sel5_out",  32'(out6),  32'h20);
                check("n6_sel5_rerr", 32'(rerr6), 32'h0);
            end
            if (s == 6) begin
                check("n6_sel6_out",  32'(out6),  32'h0);
                check("n6_sel6_rerr", 32'(rerr6), 32'h1);
            end
            #1;
        end

        // Scan from line 6 with dwell 2, wrapping to line 0.
        mode = 1'b1; load = 1'b1; sel = 3'd6; dwell = 8'd2;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("scan_out",  32'(out8),  32'(scan_out[i]));
            check("scan_wrap", 32'(wrap8), 32'(scan_wrap[i]));
            check("scan_busy", 32'(busy8), 32'(SCAN_BUILT));
            #1 load = 1'b0; dwell = 8'd7;
        end

        // Mid-scan restart with dwell 0, then abort via en low.
        load = 1'b1; sel = 3'd2; dwell = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_out", 32'(out8), 32'(mid_out[i]));
            #1 load = 1'b0;
        end
        en = 1'b0; load = 1'b1; mode = 1'b1;
        @(negedge clk);
        check("abort_out",  32'(out8),  32'h0);
        check("abort_busy", 32'(busy8), 32'h0);

        // Asynchronous reset in the middle of a dwell.
        #1 en = 1'b1; load = 1'b1; mode = 1'b1; sel = 3'd1; dwell = 8'd5;
        @(negedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check("pre_rst_out",  32'(out8),  32'h02);
        check("pre_rst_busy", 32'(busy8), 32'(SCAN_BUILT));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out",  32'(out8),  32'h0);
        check("arst_busy", 32'(busy8), 32'h0);
        check("arst_wrap", 32'(wrap8), 32'h0);
        check("arst_rerr", 32'(rerr8), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1 en = 1'b1; mode = 1'b0; load = 1'b0; sel = 3'd3;
        @(negedge clk);
        check("post_rst_out", 32'(out8), 32'h08);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            en    = ($urandom_range(0, 19) != 0);
            load  = ($urandom_range(0, 9) == 0);
            mode  = 1'($urandom_range(0, 1));
            sel   = 3'($urandom_range(0, 7));
            dwell = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(5, 30))
                                                : 8'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                @(posedge clk);
                #2 rst = 1'b1;
                @(posedge clk);
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
